// File: rtl/mips_dev_bridge.sv
// CPU-to-device bridge: window decode, strobe/ack handshake with timeout, and an interrupt mask/pending pair.
// Define BRIDGE_LEVEL_IRQ_EN to make ipend follow the dev_irq levels instead of edge-latched W1C bits.
module mips_dev_bridge #(
    parameter int          NUM_DEV       = 4,
    parameter logic [31:0] DEV_BASE      = 32'h0000_7F00,
    parameter int          DEV_SPAN_LOG2 = 4,
    parameter int          TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wd,
    input  logic                     cpu_we,
    input  logic                     cpu_re,
    output logic [31:0]              cpu_rd,
    output logic                     cpu_ready,
    output logic                     cpu_err,
    output logic [DEV_SPAN_LOG2-1:0] dev_addr,
    output logic [31:0]              dev_wd,
    output logic [NUM_DEV-1:0]       dev_we,
    output logic [NUM_DEV-1:0]       dev_re,
    input  logic [32*NUM_DEV-1:0]    dev_rd,
    input  logic [NUM_DEV-1:0]       dev_ack,
    input  logic [NUM_DEV-1:0]       dev_irq,
    output logic                     intreq,
    output logic [2:0]               irq_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                   state, state_nx;
    logic [7:0]               cnt, cnt_nx;
    logic [31:0]              rel, slot, reg_off, reg_rd, sel_rd;
    logic [DEV_SPAN_LOG2-1:0] off;
    logic                     in_win, is_dev, is_reg, ack_hit;
    logic [NUM_DEV-1:0]       req_oh, imask, ipend, act, w1c, imask_nx;
    logic [NUM_DEV-1:0]       we_nx, re_nx;
    logic [31:0]              rd_nx, wd_nx;
    logic [DEV_SPAN_LOG2-1:0] addr_nx;
    logic                     rdy_nx, err_nx;
    logic [2:0]               id_nx;
`ifndef BRIDGE_LEVEL_IRQ_EN
    logic [NUM_DEV-1:0]       irq_prev;
`endif

    assign rel     = cpu_addr - DEV_BASE;
    assign slot    = rel >> DEV_SPAN_LOG2;
    assign off     = rel[DEV_SPAN_LOG2-1:0];
    assign reg_off = 32'(off);
    assign in_win  = (cpu_we | cpu_re) && (cpu_addr >= DEV_BASE);
    assign is_dev  = slot < 32'(NUM_DEV);
    assign is_reg  = slot == 32'(NUM_DEV);
    assign act     = ipend & imask;
    // Only the channel currently strobed may complete the access.
    assign ack_hit = |(dev_ack & (dev_we | dev_re));
    assign reg_rd  = (reg_off == 32'd0) ? 32'(imask) :
                     (reg_off == 32'd4) ? 32'(ipend) : 32'd0;

    always_comb begin
        req_oh = '0;
        sel_rd = '0;
        id_nx  = 3'd0;
        for (int i = 0; i < NUM_DEV; i++) begin
            req_oh[i] = (slot == 32'(i));
            if (dev_re[i]) sel_rd = dev_rd[32*i +: 32];
        end
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (act[i]) id_nx = 3'(i);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rd_nx    = cpu_rd;
        rdy_nx   = 1'b0;
        err_nx   = 1'b0;
        addr_nx  = dev_addr;
        wd_nx    = dev_wd;
        we_nx    = dev_we;
        re_nx    = dev_re;
        imask_nx = imask;
        w1c      = '0;
        case (state)
            IDLE: begin
                if (in_win) begin
                    if (is_dev) begin
                        state_nx = ACCESS;
                        cnt_nx   = '0;
                        addr_nx  = off;
                        wd_nx    = cpu_wd;
                        if (cpu_we) we_nx = req_oh;
                        else        re_nx = req_oh;
                    end else begin
                        state_nx = DONE;
                        rdy_nx   = 1'b1;
                        rd_nx    = '0;
                        if (!is_reg) begin
                            err_nx = 1'b1;
                        end else if (cpu_we) begin
                            if (reg_off == 32'd0) imask_nx = cpu_wd[NUM_DEV-1:0];
                            if (reg_off == 32'd4) w1c      = cpu_wd[NUM_DEV-1:0];
                        end else begin
                            rd_nx = reg_rd;
                        end
                    end
                end
            end
            ACCESS: begin
                if (ack_hit) begin
                    state_nx = DONE;
                    rdy_nx   = 1'b1;
                    rd_nx    = (|dev_re) ? sel_rd : 32'd0;
                    we_nx    = '0;
                    re_nx    = '0;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state_nx = DONE;
                    rdy_nx   = 1'b1;
                    err_nx   = 1'b1;
                    rd_nx    = '0;
                    we_nx    = '0;
                    re_nx    = '0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cpu_rd    <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            dev_addr  <= '0;
            dev_wd    <= '0;
            dev_we    <= '0;
            dev_re    <= '0;
            imask     <= '0;
            ipend     <= '0;
            intreq    <= 1'b0;
            irq_id    <= 3'd0;
`ifndef BRIDGE_LEVEL_IRQ_EN
            irq_prev  <= '0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cpu_rd    <= rd_nx;
            cpu_ready <= rdy_nx;
            cpu_err   <= err_nx;
            dev_addr  <= addr_nx;
            dev_wd    <= wd_nx;
            dev_we    <= we_nx;
            dev_re    <= re_nx;
            imask     <= imask_nx;
            intreq    <= |act;
            irq_id    <= id_nx;
`ifdef BRIDGE_LEVEL_IRQ_EN
            ipend     <= dev_irq;
`else
            // A new edge beats a same-cycle W1C on the same bit.
            ipend     <= (ipend & ~w1c) | (dev_irq & ~irq_prev);
            irq_prev  <= dev_irq;
`endif
        end
    end
endmodule

// File: tb/tb_mips_dev_bridge.sv
// Randomized scoreboard bench for mips_dev_bridge with a behavioural bridge/interrupt model.
module tb_mips_dev_bridge;
    localparam int          ND   = 4;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam int          TO   = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     cpu_addr, cpu_wd;
    logic            cpu_we, cpu_re;
    logic [31:0]     cpu_rd;
    logic            cpu_ready, cpu_err;
    logic [3:0]      dev_addr;
    logic [31:0]     dev_wd;
    logic [ND-1:0]   dev_we, dev_re, dev_ack, dev_irq;
    logic [32*ND-1:0] dev_rd;
    logic            intreq;
    logic [2:0]      irq_id;

    typedef struct {
        bit          chk_rd;
        logic [31:0] rd;
        bit          err;
    } resp_t;

    resp_t         sbq[$];
    int            checks = 0;
    int            errors = 0;
    logic [ND-1:0] m_imask = '0;
    logic [ND-1:0] m_ipend = '0;
    logic [ND-1:0] irq_cur = '0;

    mips_dev_bridge #(.NUM_DEV(ND), .DEV_BASE(BASE), .DEV_SPAN_LOG2(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rd(cpu_rd), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_we(dev_we), .dev_re(dev_re),
        .dev_rd(dev_rd), .dev_ack(dev_ack), .dev_irq(dev_irq),
        .intreq(intreq), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Scoreboard monitor: every completion pulse is matched to the oldest outstanding request.
    always @(negedge clk) begin
        if (cpu_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ready", 32'(cpu_ready), 32'd0);
            end else begin
                resp_t r;
                r = sbq.pop_front();
                chk("cpu_err", 32'(cpu_err), 32'(r.err));
                if (r.chk_rd) chk("cpu_rd", cpu_rd, r.rd);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rd"},     cpu_rd, 32'd0);
        chk({tag, "_ready"},  32'(cpu_ready), 32'd0);
        chk({tag, "_err"},    32'(cpu_err), 32'd0);
        chk({tag, "_we"},     32'(dev_we), 32'd0);
        chk({tag, "_re"},     32'(dev_re), 32'd0);
        chk({tag, "_addr"},   32'(dev_addr), 32'd0);
        chk({tag, "_wd"},     dev_wd, 32'd0);
        chk({tag, "_intreq"}, 32'(intreq), 32'd0);
        chk({tag, "_irqid"},  32'(irq_id), 32'd0);
    endtask

    task automatic check_irq();
        logic [ND-1:0] a;
        int            eid;
        a   = m_ipend & m_imask;
        eid = 0;
        for (int i = ND - 1; i >= 0; i--) if (a[i]) eid = i;
        chk("intreq", 32'(intreq), 32'(|a));
        chk("irq_id", 32'(irq_id), 32'(eid));
    endtask

    // ack_k: strobe cycle on which the device acks (0 = never).
    task automatic xact(input logic [31:0] addr, input bit we, input bit re, input logic [31:0] wd,
                        input int ack_k, input logic [ND-1:0] irq_new, input logic [31:0] rdata);
        logic [31:0]   rel, slot, off;
        logic [31:0]   lanes[ND];
        logic [ND-1:0] oh, w1c, rising;
        int            kind, si, exp_str, exp_lat, n_str, lat, budget;
        bit            got;
        resp_t         r;
        rel  = addr - BASE;
        slot = rel >> 4;
        off  = rel & 32'h0000_000F;
        if (!(we || re) || addr < BASE) kind = 0;
        else if (slot < 32'(ND))        kind = 1;
        else if (slot == 32'(ND))       kind = 2;
        else                            kind = 3;
        oh = '0;
        si = 0;
        for (int i = 0; i < ND; i++) lanes[i] = $urandom;
        if (kind == 1) begin
            si        = int'(slot);
            oh[si]    = 1'b1;
            lanes[si] = rdata;
        end
        r.chk_rd = 1'b0; r.rd = 32'd0; r.err = 1'b0;
        exp_str = 0; exp_lat = 1; w1c = '0;
        rising = irq_new & ~irq_cur;
        case (kind)
            1: begin
                if (ack_k >= 1 && ack_k <= TO) begin
                    r.chk_rd = !we; r.rd = rdata; exp_str = ack_k; exp_lat = ack_k + 1;
                end else begin
                    r.chk_rd = 1'b1; r.err = 1'b1; exp_str = TO; exp_lat = TO + 1;
                end
            end
            2: begin
                if (we) begin
                    if (off == 32'd0) m_imask = wd[ND-1:0];
                    else if (off == 32'd4) w1c = wd[ND-1:0];
                end else begin
                    r.chk_rd = 1'b1;
                    r.rd = (off == 32'd0) ? 32'(m_imask) : (off == 32'd4) ? 32'(m_ipend) : 32'd0;
                end
            end
            3: r.err = 1'b1;
            default: ;
        endcase
`ifdef BRIDGE_LEVEL_IRQ_EN
        m_ipend = irq_new;
`else
        m_ipend = (m_ipend & ~w1c) | rising;
`endif
        irq_cur  = irq_new;
        cpu_addr = addr; cpu_we = we; cpu_re = re; cpu_wd = wd; dev_irq = irq_new;
        if (kind != 0) sbq.push_back(r);
        n_str = 0; lat = 0; got = 1'b0;
        budget = (kind == 0) ? 4 : 40;
        for (int c = 1; c <= budget && !got; c++) begin
            @(negedge clk);
            dev_ack = '0;
            if (cpu_ready === 1'b1) begin
                got = 1'b1; lat = c;
            end else if ((dev_we | dev_re) != '0) begin
                n_str++;
                chk("strobe_we", 32'(dev_we), we ? 32'(oh) : 32'd0);
                chk("strobe_re", 32'(dev_re), we ? 32'd0 : 32'(oh));
                if (n_str == 1) begin
                    chk("dev_addr", 32'(dev_addr), off);
                    if (we) chk("dev_wd", dev_wd, wd);
                end
                for (int i = 0; i < ND; i++) dev_rd[32*i +: 32] = lanes[i];
                dev_ack = ND'($urandom) & ~oh;
                if (n_str == ack_k) dev_ack = dev_ack | oh;
            end
        end
        dev_ack = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        if (kind == 0) begin
            chk("ignored_ready", 32'(got), 32'd0);
        end else begin
            chk("ready_seen", 32'(got), 32'd1);
            if (got) chk("latency", 32'(lat), 32'(exp_lat));
            else if (sbq.size() > 0) void'(sbq.pop_back());
        end
        chk("strobe_cycles", 32'(n_str), 32'(exp_str));
        repeat (2) @(negedge clk);
        check_irq();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, w;
        int          sel, k;
        bit          we, re;
        logic [ND-1:0] irq;
        reset = 1'b0; cpu_addr = '0; cpu_wd = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        dev_rd = '0; dev_ack = '0; dev_irq = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        xact(32'h0000_7F14, 1'b0, 1'b1, 32'd0, 3, irq_cur, 32'h1234_5678);
        xact(32'h0000_7F30, 1'b1, 1'b0, 32'hA5A5_0001, 1, irq_cur, 32'd0);
        xact(32'h0000_7F00, 1'b0, 1'b1, 32'd0, 0, irq_cur, 32'd0);
        xact(32'h0000_7F50, 1'b0, 1'b1, 32'd0, 1, irq_cur, 32'd0);
        xact(32'h0000_1000, 1'b0, 1'b1, 32'd0, 1, irq_cur, 32'd0);

        xact(32'h0000_7F40, 1'b1, 1'b0, 32'h0000_0006, 0, 4'b0000, 32'd0);
        xact(32'h0000_7F44, 1'b0, 1'b1, 32'd0, 0, 4'b0100, 32'd0);
        xact(32'h0000_7F40, 1'b0, 1'b1, 32'd0, 0, 4'b0000, 32'd0);
        xact(32'h0000_7F44, 1'b1, 1'b0, 32'h0000_0004, 0, 4'b0000, 32'd0);
        xact(32'h0000_7F44, 1'b0, 1'b1, 32'd0, 0, 4'b0001, 32'd0);
        xact(32'h0000_7F44, 1'b0, 1'b1, 32'd0, 0, 4'b0001, 32'd0);

        for (int n = 0; n < 70; n++) begin
            sel = $urandom_range(0, 9);
            w   = $urandom;
            if (sel <= 4)      a = BASE + 32'($urandom_range(0, ND - 1) * 16 + $urandom_range(0, 15));
            else if (sel <= 6) a = BASE + 32'(ND * 16 + 4 * $urandom_range(0, 3));
            else if (sel == 7) a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                 : BASE + 32'($urandom_range(ND + 1, 15) * 16 + $urandom_range(0, 15));
            else               a = 32'($urandom_range(0, 32'h7EFF));
            we = 1'($urandom_range(0, 1));
            re = we ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel == 9) begin we = 1'b0; re = 1'b0; a = BASE; end
            k   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
            irq = ($urandom_range(0, 2) == 0) ? ND'($urandom) : irq_cur;
            xact(a, we, re, w, k, irq, $urandom);
        end

        cpu_addr = BASE + 32'h20; cpu_re = 1'b1; cpu_we = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0; dev_irq = '0; irq_cur = '0;
        @(negedge clk);
        check_zero("abort");
        cpu_re = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_imask = '0; m_ipend = '0;
        @(negedge clk);
        xact(32'h0000_7F40, 1'b0, 1'b1, 32'd0, 0, 4'b0000, 32'd0);
        xact(32'h0000_7F44, 1'b0, 1'b1, 32'd0, 0, 4'b0000, 32'd0);
        xact(32'h0000_7F24, 1'b0, 1'b1, 32'd0, 2, 4'b0000, 32'hCAFE_F00D);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
